motoro3_pwm_gen_multi: RTL and testbench

Parametrised multi-channel PWM generator for the 3-phase motor drive. It is the successor to the single-channel counter-reload PWM generator.
- Per-channel duty with shadow (period-aligned) update.
- Minimum-on / minimum-off clamping to protect MOS driver rise/fall times.
- Commutation-step split into 1..4 sub-periods, with hold-off until the next step.
- Idle on zero pulse length.
- Sits between the m3 step/commutation timer (stepLast, plLen) and the phase MOS drivers.

---
 rtl/motoro3_pwm_gen_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_motoro3_pwm_gen_multi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// motoro3_pwm_gen_multi
//
// Multi-channel PWM generator for the 3-phase motor drive. It sits between
// the m3 step/commutation timer and the phase MOS drivers.
//
// Each commutation step is split into 1..4 PWM sub-periods. After the last
// sub-period the block holds its outputs low until the next step begins.
// Duty, period and minimum on/off width are sampled only at a period start,
// so changes in the middle of a period never produce partial pulses.
// Per-channel duty is clamped so that no pulse or gap is shorter than the
// MOS driver can switch.
//
// Parameters:
//   CNT_W : width of the period/duty counters
//   NCH   : number of PWM channels (phases)
//   PL_W  : width of plLen
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   enable       in   master run enable; 0 forces IDLE
//   plLen        in   commutation pulse length; 0 = motor stopped
//   stepLast     in   pulse on the last clock of a commutation step
//   pwmPeriod    in   PWM period in clocks (sampled at period start)
//   pwmWant      in   per-channel on-time, channel i at [i*CNT_W +: CNT_W]
//   pwmMinOn     in   minimum on/off width (sampled at period start)
//   stepSplitMax in   sub-periods per step minus one (sampled at step start)
//   pwm          out  registered PWM outputs
//   periodStart  out  registered pulse in the cnt==0 cycle of each period
//   subIdx       out  current sub-period index within the step
//   running      out  high while in RUN
// ---------------------------------------------------------------------------
module motoro3_pwm_gen_multi #(
    parameter int CNT_W = 12,
    parameter int NCH   = 3,
    parameter int PL_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PL_W-1:0]      plLen,
    input  logic                 stepLast,
    input  logic [CNT_W-1:0]     pwmPeriod,
    input  logic [NCH*CNT_W-1:0] pwmWant,
    input  logic [CNT_W-1:0]     pwmMinOn,
    input  logic [1:0]           stepSplitMax,
    output logic [NCH-1:0]       pwm,
    output logic                 periodStart,
    output logic [1:0]           subIdx,
    output logic                 running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Clamp a requested on-time against the minimum on/off width.
    // Pulses shorter than min_on are suppressed; gaps shorter than min_on
    // become full on. The headroom per-min_on is taken one bit wider so a
    // min_on at or above the period is recognised instead of wrapping.
    function automatic logic [CNT_W-1:0] eff_duty(
        input logic [CNT_W-1:0] want,
        input logic [CNT_W-1:0] per,
        input logic [CNT_W-1:0] min_on
    );
        logic [CNT_W:0] room;
        logic [CNT_W-1:0] res;
        room = {1'b0, per} - {1'b0, min_on};
        if (want == '0) begin
            res = '0;
        end else if ((min_on != '0) && (want < min_on)) begin
            res = '0;
        end else if (want >= per) begin
            res = per;
        end else if ((min_on != '0) &&
                     ((min_on >= per) || ({1'b0, want} > room))) begin
            res = per;
        end else begin
            res = want;
        end
        return res;
    endfunction

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                sub_q, sub_d;
    logic [1:0]                split_q, split_d;
    logic [CNT_W-1:0]          per_sh_q, per_sh_d;
    logic [NCH-1:0][CNT_W-1:0] duty_q, duty_d;
    logic [NCH-1:0]            pwm_q, pwm_d;
    logic                      ps_q, ps_d;
    logic                      run_q, run_d;

    logic                      valid_s;
    logic                      period_end_s;
    logic                      load_per_s;
    logic                      load_step_s;
    logic                      drive_s;

    assign valid_s = enable && (plLen != '0) && (pwmPeriod >= CNT_W'(2));

    // ">=" rather than "==" keeps the counter from running past the period
    // end even if the shadow were ever smaller than the count.
    assign period_end_s = (cnt_q >= (per_sh_q - CNT_W'(1)));

    // Next-state, counter and shadow-load decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        split_d     = split_q;
        per_sh_d    = per_sh_q;
        duty_d      = duty_q;
        load_per_s  = 1'b0;
        load_step_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_s) begin
                    state_d     = ST_RUN;
                    load_step_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!valid_s) begin
                    state_d = ST_IDLE;
                end else if (stepLast) begin
                    load_step_s = 1'b1;
                end else if (period_end_s) begin
                    if (sub_q < split_q) begin
                        sub_d      = sub_q + 2'd1;
                        load_per_s = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!valid_s) begin
                    state_d = ST_IDLE;
                end else if (stepLast) begin
                    state_d     = ST_RUN;
                    load_step_s = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A step start is also a period start, and restarts the sub-period count.
        if (load_step_s) begin
            load_per_s = 1'b1;
            sub_d      = 2'd0;
            split_d    = stepSplitMax;
        end else begin
            split_d = split_q;
        end

        if (load_per_s) begin
            cnt_d    = '0;
            per_sh_d = pwmPeriod;
            for (int i = 0; i < NCH; i++) begin
                duty_d[i] = eff_duty(pwmWant[i*CNT_W +: CNT_W], pwmPeriod, pwmMinOn);
            end
        end else begin
            per_sh_d = per_sh_q;
        end

        // Stopped motor parks the counter and index at zero.
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
            sub_d = 2'd0;
        end else begin
            sub_d = sub_d;
        end
    end

    // Output decode: compare is made on the current count (one clock of
    // latency), but is masked when leaving RUN so IDLE/HOLD are low at once.
    always_comb begin
        drive_s = (state_q == ST_RUN) && (state_d == ST_RUN);
        pwm_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (drive_s) begin
                pwm_d[i] = (cnt_q < duty_q[i]);
            end else begin
                pwm_d[i] = 1'b0;
            end
        end
        ps_d  = load_per_s;
        run_d = (state_d == ST_RUN);
    end

    // State, counter, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sub_q    <= 2'd0;
            split_q  <= 2'd0;
            per_sh_q <= '0;
            duty_q   <= '0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            split_q  <= split_d;
            per_sh_q <= per_sh_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
            run_q    <= run_d;
        end
    end

    assign pwm         = pwm_q;
    assign periodStart = ps_q;
    assign subIdx      = sub_q;
    assign running     = run_q;

endmodule

// File: tb/tb_motoro3_pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// Directed testbench for motoro3_pwm_gen_multi. Expected values are
// hand-computed from the cycle timeline: after the edge that starts a period
// (cnt==0, periodStart=1), pwm[i] is high for exactly duty[i] edges.
// ---------------------------------------------------------------------------
module tb_motoro3_pwm_gen_multi;

    localparam int CNT_W = 12;
    localparam int NCH   = 3;
    localparam int PL_W  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [PL_W-1:0]      plLen;
    logic                 stepLast;
    logic [CNT_W-1:0]     pwmPeriod;
    logic [NCH*CNT_W-1:0] pwmWant;
    logic [CNT_W-1:0]     pwmMinOn;
    logic [1:0]           stepSplitMax;
    logic [NCH-1:0]       pwm;
    logic                 periodStart;
    logic [1:0]           subIdx;
    logic                 running;

    int total = 0;
    int bad   = 0;
    int hi0, hi1, hi2, ps_n;

    motoro3_pwm_gen_multi #(.CNT_W(CNT_W), .NCH(NCH), .PL_W(PL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .plLen        (plLen),
        .stepLast     (stepLast),
        .pwmPeriod    (pwmPeriod),
        .pwmWant      (pwmWant),
        .pwmMinOn     (pwmMinOn),
        .stepSplitMax (stepSplitMax),
        .pwm          (pwm),
        .periodStart  (periodStart),
        .subIdx       (subIdx),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_want(input int w0, input int w1, input int w2);
        pwmWant = {CNT_W'(w2), CNT_W'(w1), CNT_W'(w0)};
    endtask

    task automatic clr();
        hi0 = 0; hi1 = 0; hi2 = 0; ps_n = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            hi0  += int'(pwm[0]);
            hi1  += int'(pwm[1]);
            hi2  += int'(pwm[2]);
            ps_n += int'(periodStart);
        end
    endtask

    // Pulse reset for one edge, then release with current inputs.
    task automatic do_reset();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; plLen = 16'd100; stepLast = 1'b0;
        pwmPeriod = 12'd1; pwmMinOn = 12'd0; stepSplitMax = 2'd3;
        set_want(3, 5, 0);

        // ---- reset state
        run(2);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_ps", 32'(periodStart), 32'd0);
        chk("rst_sub", 32'(subIdx), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        rst = 1'b0;

        // ---- period < 2 is invalid, stepLast in IDLE ignored
        stepLast = 1'b1;
        run(2);
        stepLast = 1'b0;
        chk("per1_idle", 32'(running), 32'd0);

        // ---- basic duty: period 10, want {3,5,0}, split 3
        pwmPeriod = 12'd10;
        run(1);
        chk("b_start_run", 32'(running), 32'd1);
        chk("b_start_ps", 32'(periodStart), 32'd1);
        chk("b_start_pwm", 32'(pwm), 32'd0);
        clr(); run(10);
        chk("b_hi0", 32'(hi0), 32'd3);
        chk("b_hi1", 32'(hi1), 32'd5);
        chk("b_hi2", 32'(hi2), 32'd0);
        chk("b_ps", 32'(ps_n), 32'd1);
        chk("b_sub1", 32'(subIdx), 32'd1);
        clr(); run(30);
        chk("b_hi0_3p", 32'(hi0), 32'd9);
        chk("b_hi1_3p", 32'(hi1), 32'd15);
        chk("b_ps_3p", 32'(ps_n), 32'd2);
        chk("b_hold_run", 32'(running), 32'd0);
        chk("b_hold_pwm", 32'(pwm), 32'd0);
        chk("b_hold_sub", 32'(subIdx), 32'd3);
        clr(); run(3);
        chk("b_hold_quiet", 32'(ps_n + hi0 + hi1), 32'd0);
        stepLast = 1'b1;
        run(1);
        stepLast = 1'b0;
        chk("b_resume_ps", 32'(periodStart), 32'd1);
        chk("b_resume_sub", 32'(subIdx), 32'd0);
        chk("b_resume_run", 32'(running), 32'd1);
        chk("b_resume_pwm0", 32'(pwm), 32'd0);
        run(1);
        chk("b_resume_pwm1", 32'(pwm), 32'd3);

        // ---- min clamp: period 10, min 2, want {1,9,8}
        pwmMinOn = 12'd2;
        set_want(1, 9, 8);
        do_reset();
        run(1);
        chk("m_start", 32'(periodStart), 32'd1);
        clr(); run(20);
        chk("m_hi0", 32'(hi0), 32'd0);
        chk("m_hi1_full", 32'(hi1), 32'd20);
        chk("m_hi2", 32'(hi2), 32'd16);
        chk("m_ps", 32'(ps_n), 32'd2);

        // ---- split/hold: period 8, split 1, want 4
        pwmPeriod = 12'd8; pwmMinOn = 12'd0; stepSplitMax = 2'd1;
        set_want(4, 4, 4);
        do_reset();
        run(1);
        clr(); run(16);
        chk("s_hi0", 32'(hi0), 32'd8);
        chk("s_ps", 32'(ps_n), 32'd1);
        chk("s_hold_run", 32'(running), 32'd0);
        chk("s_hold_pwm", 32'(pwm), 32'd0);
        chk("s_hold_sub", 32'(subIdx), 32'd1);
        clr(); run(3);
        chk("s_hold_quiet", 32'(ps_n + hi0), 32'd0);
        stepLast = 1'b1;
        run(1);
        stepLast = 1'b0;
        chk("s_resume_ps", 32'(periodStart), 32'd1);
        chk("s_resume_sub", 32'(subIdx), 32'd0);
        chk("s_resume_pwm0", 32'(pwm), 32'd0);
        run(1);
        chk("s_resume_pwm1", 32'(pwm), 32'd7);

        // ---- mid-period changes and restart: period 20, want 10
        pwmPeriod = 12'd20; stepSplitMax = 2'd3;
        set_want(10, 10, 10);
        do_reset();
        run(1);
        run(12);
        set_want(15, 15, 15);
        clr(); run(8);
        chk("r_nochange_hi0", 32'(hi0), 32'd0);
        chk("r_ps", 32'(ps_n), 32'd1);
        chk("r_sub1", 32'(subIdx), 32'd1);
        clr(); run(3);
        chk("r_hi0_15a", 32'(hi0), 32'd3);
        set_want(6, 6, 6);
        clr(); run(2);
        chk("r_hi0_15b", 32'(hi0), 32'd2);
        stepLast = 1'b1;
        run(1);
        stepLast = 1'b0;
        chk("r_restart_ps", 32'(periodStart), 32'd1);
        chk("r_restart_sub", 32'(subIdx), 32'd0);
        chk("r_restart_pwm", 32'(pwm), 32'd7);
        clr(); run(20);
        chk("r_hi0_6", 32'(hi0), 32'd6);
        chk("r_ps2", 32'(ps_n), 32'd1);

        // ---- stop/idle: plLen -> 0 at cnt 3 with pwm high
        run(3);
        chk("i_pwm_high", 32'(pwm), 32'd7);
        plLen = 16'd0;
        run(1);
        chk("i_stop_pwm", 32'(pwm), 32'd0);
        chk("i_stop_run", 32'(running), 32'd0);
        clr(); run(2);
        chk("i_idle_quiet", 32'(ps_n + hi0), 32'd0);
        plLen = 16'd100;
        run(1);
        chk("i_go_run", 32'(running), 32'd1);
        chk("i_go_ps", 32'(periodStart), 32'd1);
        chk("i_go_sub", 32'(subIdx), 32'd0);
        run(1);
        chk("i_go_pwm", 32'(pwm), 32'd7);

        // ---- reset mid-pulse
        run(2);
        rst = 1'b1;
        run(1);
        chk("x_rst_pwm", 32'(pwm), 32'd0);
        chk("x_rst_run", 32'(running), 32'd0);
        chk("x_rst_ps", 32'(periodStart), 32'd0);
        rst = 1'b0;
        run(1);
        chk("x_after_ps", 32'(periodStart), 32'd1);
        chk("x_after_run", 32'(running), 32'd1);
        chk("x_after_pwm", 32'(pwm), 32'd0);

        // ---- enable low forces idle
        enable = 1'b0;
        run(1);
        chk("e_off_run", 32'(running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
